seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the hex-to-seven-segment encoder.
- Samples a time-multiplexed 7-segment bus (segment lines plus active-low digit anodes) driven by the display scanner.
- Filters each digit dwell for stability, decodes each segment pattern back to a hex nibble, and assembles a full multi-digit value.
- Used on-board and in benches to read back what the pipeline is actually displaying, with per-digit error flags for illegal patterns.

---
 rtl/seg7_scan_decoder.sv | 108 ++++++++++
 tb/tb_seg7_scan_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed 7-segment bus, filters each digit dwell,
// decodes patterns back to hex nibbles and assembles full frames.
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   value_out,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  frame_valid,
    output logic [7:0]            frame_cnt
);
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [DIGITS+6:0]   prev_q, prev_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                captured_q, captured_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [DIGITS-1:0]   shadow_err_q, shadow_err_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic                fv_q, fv_d;
    logic [7:0]          fcnt_q, fcnt_d;
    logic                same, capture, complete, dec_err;
    logic [3:0]          dec_nib;
    logic [DIGITS-1:0]   cap_mask, seen_all;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = 5'h00;
            7'h06: decode = 5'h01;
            7'h5B: decode = 5'h02;
            7'h4F: decode = 5'h03;
            7'h66: decode = 5'h04;
            7'h6D: decode = 5'h05;
            7'h7D: decode = 5'h06;
            7'h07: decode = 5'h07;
            7'h7F: decode = 5'h08;
            7'h6F: decode = 5'h09;
            7'h77: decode = 5'h0A;
            7'h7C: decode = 5'h0B;
            7'h39: decode = 5'h0C;
            7'h5E: decode = 5'h0D;
            7'h79: decode = 5'h0E;
            7'h71: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    always_comb begin
        prev_d       = {an_in, seg_in};
        same         = prev_d == prev_q;
        cnt_d        = same ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1) : 8'd0;
        // cnt_d reaching CNT_MAX means STABLE_CYCLES identical edges including this one
        capture      = same && (cnt_d == CNT_MAX) && !captured_q && $onehot(~an_in);
        captured_d   = same && (captured_q || capture);
        cap_mask     = capture ? ~an_in : '0;
        {dec_err, dec_nib} = decode(seg_in);
        shadow_d     = shadow_q;
        shadow_err_d = shadow_err_q;
        for (int i = 0; i < DIGITS; i++) begin
            shadow_d[4*i+:4] = cap_mask[i] ? dec_nib : shadow_q[4*i+:4];
            shadow_err_d[i]  = cap_mask[i] ? dec_err : shadow_err_q[i];
        end
        seen_all     = seen_q | cap_mask;
        complete     = capture && (&seen_all);
        seen_d       = complete ? '0 : seen_all;
        value_d      = complete ? shadow_d : value_q;
        err_d        = complete ? shadow_err_d : err_q;
        fv_d         = complete;
        fcnt_d       = fcnt_q + {7'd0, complete};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q       <= {{DIGITS{1'b1}}, 7'd0};
            cnt_q        <= '0;
            captured_q   <= 1'b0;
            seen_q       <= '0;
            shadow_q     <= '0;
            shadow_err_q <= '0;
            value_q      <= '0;
            err_q        <= '0;
            fv_q         <= 1'b0;
            fcnt_q       <= '0;
        end else begin
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            captured_q   <= captured_d;
            seen_q       <= seen_d;
            shadow_q     <= shadow_d;
            shadow_err_q <= shadow_err_d;
            value_q      <= value_d;
            err_q        <= err_d;
            fv_q         <= fv_d;
            fcnt_q       <= fcnt_d;
        end
    end

    assign value_out   = value_q;
    assign digit_err   = err_q;
    assign frame_valid = fv_q;
    assign frame_cnt   = fcnt_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: table-driven and randomized checks of seg7_scan_decoder
// against a per-cycle behavioural model of dwell filtering and frame assembly.
module tb_seg7_scan_decoder;
    localparam int D = 4;
    localparam int S = 4;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        logic [15:0] val;
        logic [3:0]  err;
        logic        fv;
        logic [7:0]  fcnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = 7'd0;
    logic [3:0]  an_in = 4'hF;
    logic [15:0] value_out;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;
    int dut_pulses = 0;
    int m_pulses = 0;

    logic [6:0] pats [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [3:0]  m_last_an;
    logic [6:0]  m_last_seg;
    int          m_run;
    logic [3:0]  m_sh [4];
    bit          m_she [4];
    bit          m_seen [4];
    logic [15:0] m_val;
    logic [3:0]  m_err;
    logic        m_fv;
    logic [7:0]  m_fcnt;

    vec_t vecs [$];

    seg7_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
        .value_out(value_out), .digit_err(digit_err),
        .frame_valid(frame_valid), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_dec(input logic [6:0] s);
        for (int n = 0; n < 16; n++)
            if (pats[n] == s) return {1'b0, 4'(n)};
        return 5'h10;
    endfunction

    function automatic void model_reset();
        m_last_an = 4'hF;
        m_last_seg = 7'd0;
        m_run = 1;
        for (int n = 0; n < 4; n++) begin
            m_sh[n] = 4'd0;
            m_she[n] = 1'b0;
            m_seen[n] = 1'b0;
        end
        m_val = 16'd0;
        m_err = 4'd0;
        m_fv = 1'b0;
        m_fcnt = 8'd0;
    endfunction

    // One clock edge of the reference: a dwell captures when its S-th identical sample arrives
    function automatic void model_step(input logic [3:0] an, input logic [6:0] seg);
        logic [4:0] d;
        int k;
        bit all;
        if (an == m_last_an && seg == m_last_seg) m_run++;
        else begin
            m_run = 1;
            m_last_an = an;
            m_last_seg = seg;
        end
        m_fv = 1'b0;
        if (m_run == S && $countones(~an) == 1) begin
            k = 0;
            for (int n = 0; n < 4; n++) if (!an[n]) k = n;
            d = ref_dec(seg);
            m_sh[k] = d[3:0];
            m_she[k] = d[4];
            m_seen[k] = 1'b1;
            all = 1'b1;
            for (int n = 0; n < 4; n++) all &= m_seen[n];
            if (all) begin
                for (int n = 0; n < 4; n++) begin
                    m_val[4*n+:4] = m_sh[n];
                    m_err[n] = m_she[n];
                    m_seen[n] = 1'b0;
                end
                m_fv = 1'b1;
                m_fcnt = m_fcnt + 8'd1;
                m_pulses++;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(an_in, seg_in);
        #1;
        if (frame_valid) dut_pulses++;
        chk("cyc_value", {16'd0, value_out}, {16'd0, m_val});
        chk("cyc_err", {28'd0, digit_err}, {28'd0, m_err});
        chk("cyc_fv", {31'd0, frame_valid}, {31'd0, m_fv});
        chk("cyc_fcnt", {24'd0, frame_cnt}, {24'd0, m_fcnt});
    endtask

    task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in = an;
        seg_in = seg;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        an_in = 4'hF;
        seg_in = 7'd0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_value", {16'd0, value_out}, 32'd0);
        chk("rst_err", {28'd0, digit_err}, 32'd0);
        chk("rst_fv", {31'd0, frame_valid}, 32'd0);
        chk("rst_fcnt", {24'd0, frame_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    function automatic void add(input logic [3:0] an, input logic [6:0] seg, input int hold,
                                input logic [15:0] val, input logic [3:0] err,
                                input logic fv, input logic [7:0] fcnt);
        vec_t v;
        v.an = an; v.seg = seg; v.hold = hold;
        v.val = val; v.err = err; v.fv = fv; v.fcnt = fcnt;
        vecs.push_back(v);
    endfunction

    initial begin
        int p0, iter;
        int perm [4];
        logic [6:0] sg;
        // full frame 0xBEEF, last dwell split to pin the capture edge
        add(4'b1110, 7'h71, 10, 16'h0000, 4'h0, 1'b0, 8'd0);
        add(4'b1101, 7'h79, 10, 16'h0000, 4'h0, 1'b0, 8'd0);
        add(4'b1011, 7'h79, 10, 16'h0000, 4'h0, 1'b0, 8'd0);
        add(4'b0111, 7'h7C, 3,  16'h0000, 4'h0, 1'b0, 8'd0);
        add(4'b0111, 7'h7C, 1,  16'hBEEF, 4'h0, 1'b1, 8'd1);
        add(4'b0111, 7'h7C, 6,  16'hBEEF, 4'h0, 1'b0, 8'd1);
        // glitch rejection: 3-cycle dwells then 10-cycle dwells of 0x1234
        add(4'b1110, 7'h66, 3,  16'hBEEF, 4'h0, 1'b0, 8'd1);
        add(4'b1101, 7'h4F, 3,  16'hBEEF, 4'h0, 1'b0, 8'd1);
        add(4'b1011, 7'h5B, 3,  16'hBEEF, 4'h0, 1'b0, 8'd1);
        add(4'b0111, 7'h06, 3,  16'hBEEF, 4'h0, 1'b0, 8'd1);
        add(4'b1110, 7'h66, 10, 16'hBEEF, 4'h0, 1'b0, 8'd1);
        add(4'b1101, 7'h4F, 10, 16'hBEEF, 4'h0, 1'b0, 8'd1);
        add(4'b1011, 7'h5B, 10, 16'hBEEF, 4'h0, 1'b0, 8'd1);
        add(4'b0111, 7'h06, 10, 16'h1234, 4'h0, 1'b0, 8'd2);
        // illegal pattern on digit 2
        add(4'b1110, 7'h66, 10, 16'h1234, 4'h0, 1'b0, 8'd2);
        add(4'b1101, 7'h4F, 10, 16'h1234, 4'h0, 1'b0, 8'd2);
        add(4'b1011, 7'h00, 10, 16'h1234, 4'h0, 1'b0, 8'd2);
        add(4'b0111, 7'h06, 10, 16'h1034, 4'b0100, 1'b0, 8'd3);
        // bad anode patterns, then a legal scan
        add(4'b1100, 7'h66, 20, 16'h1034, 4'b0100, 1'b0, 8'd3);
        add(4'b1111, 7'h66, 20, 16'h1034, 4'b0100, 1'b0, 8'd3);
        add(4'b1110, 7'h66, 10, 16'h1034, 4'b0100, 1'b0, 8'd3);
        add(4'b1101, 7'h4F, 10, 16'h1034, 4'b0100, 1'b0, 8'd3);
        add(4'b1011, 7'h5B, 10, 16'h1034, 4'b0100, 1'b0, 8'd3);
        add(4'b0111, 7'h06, 10, 16'h1234, 4'h0, 1'b0, 8'd4);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        foreach (vecs[i]) begin
            dwell(vecs[i].an, vecs[i].seg, vecs[i].hold);
            chk($sformatf("vec%0d_value", i), {16'd0, value_out}, {16'd0, vecs[i].val});
            chk($sformatf("vec%0d_err", i), {28'd0, digit_err}, {28'd0, vecs[i].err});
            chk($sformatf("vec%0d_fv", i), {31'd0, frame_valid}, {31'd0, vecs[i].fv});
            chk($sformatf("vec%0d_fcnt", i), {24'd0, frame_cnt}, {24'd0, vecs[i].fcnt});
        end
        chk("table_pulses", dut_pulses, 4);

        // reset mid-frame on 0xA5A5
        dwell(4'b1110, 7'h6D, 10);
        dwell(4'b1101, 7'h77, 10);
        do_reset();
        p0 = dut_pulses;
        dwell(4'b1011, 7'h6D, 10);
        dwell(4'b0111, 7'h77, 10);
        chk("rstmid_value", {16'd0, value_out}, 32'd0);
        chk("rstmid_fcnt", {24'd0, frame_cnt}, 32'd0);
        chk("rstmid_pulses", dut_pulses - p0, 0);
        dwell(4'b1110, 7'h6D, 10);
        dwell(4'b1101, 7'h77, 10);
        chk("rstmid_final", {16'd0, value_out}, 32'h0000A5A5);
        chk("rstmid_fcnt1", {24'd0, frame_cnt}, 32'd1);

        // randomized frames up to a full counter wrap
        do_reset();
        p0 = dut_pulses;
        m_pulses = 0;
        iter = 0;
        while (m_pulses < 256 && iter < 400) begin
            iter++;
            perm = '{0, 1, 2, 3};
            for (int i = 3; i > 0; i--) begin
                int j, t;
                j = $urandom_range(0, i);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 4) == 0)
                    dwell(~(4'b0001 << $urandom_range(0, 3)), 7'($urandom), $urandom_range(1, 3));
                sg = ($urandom_range(0, 7) == 0) ? 7'($urandom) : pats[$urandom_range(0, 15)];
                dwell(~(4'b0001 << perm[i]), sg, $urandom_range(4, 6));
            end
            dwell(4'hF, 7'd0, 1);
        end
        chk("wrap_model_frames", m_pulses, 256);
        chk("wrap_pulses", dut_pulses - p0, 256);
        chk("wrap_fcnt", {24'd0, frame_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
